// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: word geometry and FSM states.
package imem_loader_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_LEN  = 2'd0,
        ST_DATA = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and load status of the loader.
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) ();

    logic              in_valid;
    logic [BYTE_W-1:0] in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              core_rst;
    logic              done;
    logic              err;

    modport master (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, core_rst, done, err
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, core_rst, done, err
    );

endinterface

// File: rtl/imem_loader_byte_pack.sv
// Little-endian byte-to-word packer: word_valid fires on the cycle the fourth byte is accepted.
module imem_byte_pack
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    localparam int unsigned SR_W = WORD_W - BYTE_W;

    logic [1:0]      cnt_q, cnt_d;
    logic [SR_W-1:0] sr_q, sr_d;

    // Bytes enter at the top and shift down, so the oldest ends up in [7:0].
    always_comb begin
        cnt_d = cnt_q;
        sr_d  = sr_q;
        if (byte_valid) begin
            cnt_d = cnt_q + 2'd1;
            sr_d  = {byte_data, sr_q[SR_W-1:BYTE_W]};
        end
    end

    assign word_valid = byte_valid && (cnt_q == 2'd3);
    assign word       = {byte_data, sr_q};

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
            sr_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory, then releases the core from reset.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input logic           clk,
    input logic           rst,
    imem_loader_if.master bus
);

    localparam int unsigned       CNT_W = ADDR_W + 1;
    localparam logic [WORD_W-1:0] DEPTH = 1 << ADDR_W;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic              in_ready_q, in_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              core_rst_q, core_rst_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept;
    logic              word_valid;
    logic [WORD_W-1:0] word;

    assign accept = bus.in_valid && in_ready_q;

    imem_byte_pack u_pack (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (accept),
        .byte_data  (bus.in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    // DATA is left one cycle after the final word so the write cycle still has core_rst=1;
    // in_ready is dropped for that cycle because the count is already satisfied.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        idx_d       = idx_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            ST_LEN: begin
                if (word_valid) begin
                    n_d = word[CNT_W-1:0];
                    if ((word == '0) || (word > DEPTH)) state_d = ST_ERR;
                    else                                state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (word_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = idx_q[ADDR_W-1:0];
                    mem_wdata_d = word;
                    idx_d       = idx_q + 1'b1;
                end else if (idx_q == n_q) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = state_q;
        endcase
        in_ready_d = (state_d == ST_LEN) || ((state_d == ST_DATA) && (idx_d != n_d));
        core_rst_d = (state_d != ST_DONE);
        done_d     = (state_d == ST_DONE);
        err_d      = (state_d == ST_ERR);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_LEN;
            n_q         <= '0;
            idx_q       <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            core_rst_q  <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            core_rst_q  <= core_rst_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.core_rst  = core_rst_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: byte-queue reference model compared every cycle, plus directed load scenarios.
module tb_imem_loader;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 256;
    localparam int P_LEN = 0, P_DATA = 1, P_DONE = 2, P_ERR = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;
    logic [39:0] wlog[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: collects accepted bytes, forms words, and derives the expected outputs.
    bit          m_ready = 1'b0, m_we = 1'b0, m_core_rst = 1'b1, m_done = 1'b0, m_err = 1'b0;
    logic [7:0]  m_addr  = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_n     = '0;
    int          m_phase = P_LEN;
    int          m_widx  = 0;
    logic [7:0]  m_bytes[$];

    always @(posedge clk) begin : model
        logic [31:0] w;
        if (!rst) begin
            m_bytes.delete();
            m_phase = P_LEN; m_n = '0; m_widx = 0;
            m_ready = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
        end else begin
            m_we = 1'b0;
            if (bus.in_valid && m_ready) begin
                m_bytes.push_back(bus.in_data);
                if (m_bytes.size() == 4) begin
                    w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                    m_bytes.delete();
                    if (m_phase == P_LEN) begin
                        m_n = w;
                        m_widx = 0;
                        m_phase = (w == 0 || w > DEPTH) ? P_ERR : P_DATA;
                    end else begin
                        m_we = 1'b1;
                        m_addr = 8'(m_widx);
                        m_wdata = w;
                        m_widx++;
                    end
                end
            end else if (m_phase == P_DATA && m_widx == m_n) begin
                m_phase = P_DONE;
            end
            m_ready = (m_phase == P_LEN) || (m_phase == P_DATA && m_widx < m_n);
        end
        m_core_rst = (m_phase != P_DONE);
        m_done     = (m_phase == P_DONE);
        m_err      = (m_phase == P_ERR);
    end

    always @(negedge clk) begin : compare
        if (chk_en) begin
            chk("in_ready", bus.in_ready, m_ready);
            chk("mem_we",   bus.mem_we,   m_we);
            chk("core_rst", bus.core_rst, m_core_rst);
            chk("done",     bus.done,     m_done);
            chk("err",      bus.err,      m_err);
            if (m_we) begin
                chk("mem_addr",  bus.mem_addr,  m_addr);
                chk("mem_wdata", bus.mem_wdata, m_wdata);
            end
            if (bus.mem_we) wlog.push_back({bus.mem_addr, bus.mem_wdata});
        end
    end

    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        wlog.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int t;
        bit acc;
        t = 0;
        forever begin
            if (rnd && $urandom_range(0, 1) == 0) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                @(posedge clk); #1;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = b;
                acc = bus.in_ready;
                @(posedge clk); #1;
                if (acc) break;
            end
            t++;
            if (t > 200) begin
                chk("byte_accept_timeout", 32'(t), 32'd0);
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit rnd);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], rnd);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_end();
        int t;
        t = 0;
        while (!(bus.done || bus.err) && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("end_timeout", 32'(t < 50), 32'd1);
        idle(2);
    endtask

    task automatic check_two_word_load(input string tag);
        chk({tag, "_nwrites"}, 32'(wlog.size()), 32'd2);
        if (wlog.size() >= 2) begin
            chk({tag, "_w0_addr"}, 32'(wlog[0][39:32]), 32'h0);
            chk({tag, "_w0_data"}, wlog[0][31:0], 32'h00500093);
            chk({tag, "_w1_addr"}, 32'(wlog[1][39:32]), 32'h1);
            chk({tag, "_w1_data"}, wlog[1][31:0], 32'h00100113);
        end
        chk({tag, "_done"},     32'(bus.done),     32'd1);
        chk({tag, "_core_rst"}, 32'(bus.core_rst), 32'd0);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    endtask

    initial begin : global_timeout
        #1_000_000;
        miscompares++;
        $display("FAIL global_timeout: simulation did not finish within 1 ms");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "global timeout");
    end

    initial begin : stimulus
        int n;
        logic [31:0] cnt;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
        chk("rst_mem_we",    32'(bus.mem_we),    32'd0);
        chk("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
        chk("rst_mem_wdata", bus.mem_wdata,      32'd0);
        chk("rst_core_rst",  32'(bus.core_rst),  32'd1);
        chk("rst_done",      32'(bus.done),      32'd0);
        chk("rst_err",       32'(bus.err),       32'd0);

        // Two-word load at full rate, then extra bytes that must be refused.
        do_reset();
        idle(1);
        send_word(32'd2, 1'b0);
        send_word(32'h00500093, 1'b0);
        send_word(32'h00100113, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        repeat (4) begin
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        wait_end();
        check_two_word_load("full_rate");

        // Zero count.
        do_reset();
        idle(1);
        send_word(32'd0, 1'b0);
        wait_end();
        idle(5);
        chk("zero_err",      32'(bus.err),      32'd1);
        chk("zero_nwrites",  32'(wlog.size()),  32'd0);
        chk("zero_core_rst", 32'(bus.core_rst), 32'd1);
        chk("zero_in_ready", 32'(bus.in_ready), 32'd0);

        // Count one past the memory depth.
        do_reset();
        idle(1);
        send_word(32'd257, 1'b0);
        wait_end();
        chk("over_err",     32'(bus.err),     32'd1);
        chk("over_done",    32'(bus.done),    32'd0);
        chk("over_nwrites", 32'(wlog.size()), 32'd0);

        // Same two-word load with in_valid toggling randomly.
        do_reset();
        idle(1);
        send_word(32'd2, 1'b1);
        send_word(32'h00500093, 1'b1);
        send_word(32'h00100113, 1'b1);
        wait_end();
        check_two_word_load("gappy");

        // Reset mid-load discards the partial second word.
        do_reset();
        idle(1);
        send_word(32'd2, 1'b0);
        send_word(32'h11223344, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        idle(1);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        idle(3);
        chk("midrst_nwrites",  32'(wlog.size()),  32'd1);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_core_rst", 32'(bus.core_rst), 32'd1);
        chk("midrst_done",     32'(bus.done),     32'd0);
        chk("midrst_err",      32'(bus.err),      32'd0);
        wlog.delete();
        send_word(32'd1, 1'b0);
        send_word(32'hCAFEF00D, 1'b0);
        wait_end();
        chk("fresh_nwrites", 32'(wlog.size()), 32'd1);
        if (wlog.size() >= 1) begin
            chk("fresh_addr", 32'(wlog[0][39:32]), 32'h0);
            chk("fresh_data", wlog[0][31:0], 32'hCAFEF00D);
        end
        chk("fresh_done", 32'(bus.done), 32'd1);

        // Full-depth load with words equal to their index.
        do_reset();
        idle(1);
        send_word(32'd256, 1'b0);
        for (int i = 0; i < 256; i++) send_word(32'(i), 1'b0);
        wait_end();
        chk("full_nwrites", 32'(wlog.size()), 32'd256);
        if (wlog.size() >= 1) begin
            chk("full_last_addr", 32'(wlog[$][39:32]), 32'hFF);
            chk("full_last_data", wlog[$][31:0], 32'h000000FF);
        end
        chk("full_done", 32'(bus.done), 32'd1);

        // Random loads, occasionally with an invalid count.
        for (int k = 0; k < 6; k++) begin
            do_reset();
            idle(1);
            case ($urandom_range(0, 5))
                0:       cnt = 32'd0;
                1:       cnt = 32'($urandom_range(257, 4000));
                default: cnt = 32'($urandom_range(1, 10));
            endcase
            send_word(cnt, 1'b1);
            if (cnt >= 1 && cnt <= DEPTH) begin
                n = int'(cnt);
                for (int i = 0; i < n; i++) send_word($urandom, 1'b1);
                wait_end();
                chk("rand_nwrites", 32'(wlog.size()), cnt);
                chk("rand_done", 32'(bus.done), 32'd1);
            end else begin
                wait_end();
                chk("rand_err", 32'(bus.err), 32'd1);
                chk("rand_nwrites_err", 32'(wlog.size()), 32'd0);
            end
        end

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
